// File: rtl/ma_clk_cfg_pkg.sv
// Shared types and constants for the clock-group reconfiguration sequencer.
package ma_clk_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_OFF,
        ST_PROG,
        ST_WAIT_SET,
        ST_DONE
    } clk_seq_state_e;

    localparam int DOM_CPU   = 0;
    localparam int DOM_AXI   = 1;
    localparam int DOM_APB   = 2;
    localparam int DOM_I2C   = 3;
    localparam int DOM_IMP   = 4;
    localparam int N_DOM_DEF = 5;
    localparam int DOM_W     = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ma_clk_cfg_seq_if.sv
// Update-request handshake between the system register block and the sequencer.
interface ma_clk_cfg_seq_if #(
    parameter int DIV_DW = 4
);
    import ma_clk_cfg_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DOM_W-1:0]  req_dom;
    logic [DIV_DW-1:0] req_div;
    logic              req_cken;
    logic              done_o;
    logic              err_o;
    logic              busy_o;

    modport master (
        output req_valid, req_dom, req_div, req_cken,
        input  req_ready, done_o, err_o, busy_o
    );

    modport slave (
        input  req_valid, req_dom, req_div, req_cken,
        output req_ready, done_o, err_o, busy_o
    );

endinterface

// File: rtl/ma_clk_seq_timer.sv
// Loadable down-counter with zero flag; shared by the gate-off and settle waits.
module ma_clk_seq_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ma_clk_cfg_seq.sv
// Gates one clock domain off, reprograms its divider/enable with a toggle flip,
// waits for the divider to settle, then lets the ICG follow software again.
module ma_clk_cfg_seq
    import ma_clk_cfg_pkg::*;
#(
    parameter int                DIV_DW      = 4,
    parameter int                N_DOM       = N_DOM_DEF,
    parameter int                GATE_WAIT   = 8,
    parameter int                SETTLE_WAIT = 32,
    parameter logic [DIV_DW-1:0] DIV_RST     = DIV_DW'(1)
) (
    input  logic                    src_clk,
    input  logic                    src_rst_n,
    ma_clk_cfg_seq_if.slave         req_if,
    input  logic [N_DOM-1:0]        icg_en_i,
    output logic [N_DOM*DIV_DW-1:0] clk_div_o,
    output logic [N_DOM-1:0]        clk_tog_o,
    output logic [N_DOM-1:0]        clk_cken_o,
    output logic [N_DOM-1:0]        icg_on_o
);

    localparam int CNT_MAX = max_int(max_int(GATE_WAIT, SETTLE_WAIT), 2);
    localparam int CNT_W   = $clog2(CNT_MAX);

    // The divider must see at least two full output periods before ungating.
    generate
        if (SETTLE_WAIT < 2 * (1 << DIV_DW)) begin : g_bad_settle
            $error("SETTLE_WAIT must be at least 2*2^DIV_DW");
        end
        if (GATE_WAIT < 1) begin : g_bad_gate
            $error("GATE_WAIT must be at least 1");
        end
    endgenerate

    clk_seq_state_e     state_reg;
    logic [DOM_W-1:0]   dom_reg;
    logic [DIV_DW-1:0]  div_reg;
    logic               cken_reg;
    logic [N_DOM-1:0]   mask_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;

    logic [N_DOM-1:0]   dom_hit;
    logic [N_DOM-1:0]   req_hit;
    logic               req_dom_ok;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_dec;
    logic               tmr_zero;

    assign req_dom_ok = (32'(req_if.req_dom) < N_DOM);

    generate
        for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
            assign dom_hit[gi] = (32'(dom_reg) == gi);
            assign req_hit[gi] = (32'(req_if.req_dom) == gi);
        end
    endgenerate

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_if.req_valid && req_dom_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GATE_WAIT - 1);
                end
            end
            ST_WAIT_OFF: tmr_dec = !tmr_zero;
            ST_PROG: begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(SETTLE_WAIT - 1);
            end
            ST_WAIT_SET: tmr_dec = !tmr_zero;
            default: ;
        endcase
    end

    ma_clk_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (src_clk),
        .rst_n    (src_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge src_clk) begin
        if (!src_rst_n) begin
            state_reg  <= ST_IDLE;
            dom_reg    <= '0;
            div_reg    <= '0;
            cken_reg   <= 1'b0;
            mask_reg   <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            clk_div_o  <= {N_DOM{DIV_RST}};
            clk_tog_o  <= '0;
            clk_cken_o <= '1;
            icg_on_o   <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            // A domain with its divider disabled never gets its gate reopened.
            icg_on_o <= icg_en_i & ~mask_reg & clk_cken_o;
            case (state_reg)
                ST_IDLE: begin
                    if (req_if.req_valid) begin
                        if (!req_dom_ok) begin
                            err_reg <= 1'b1;
                        end else begin
                            dom_reg   <= req_if.req_dom;
                            div_reg   <= req_if.req_div;
                            cken_reg  <= req_if.req_cken;
                            mask_reg  <= mask_reg | req_hit;
                            ready_reg <= 1'b0;
                            busy_reg  <= 1'b1;
                            state_reg <= ST_WAIT_OFF;
                        end
                    end
                end
                ST_WAIT_OFF: begin
                    if (tmr_zero) state_reg <= ST_PROG;
                end
                ST_PROG: begin
                    for (int d = 0; d < N_DOM; d++) begin
                        if (dom_hit[d]) begin
                            clk_div_o[d*DIV_DW +: DIV_DW] <= div_reg;
                            clk_cken_o[d]                 <= cken_reg;
                            clk_tog_o[d]                  <= ~clk_tog_o[d];
                        end
                    end
                    state_reg <= ST_WAIT_SET;
                end
                ST_WAIT_SET: begin
                    if (tmr_zero) state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    mask_reg  <= mask_reg & ~dom_hit;
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_if.req_ready = ready_reg;
    assign req_if.busy_o    = busy_reg;
    assign req_if.done_o    = done_reg;
    assign req_if.err_o     = err_reg;

endmodule
